// File: rtl/gauge_pkg.sv
// Shared types and constants for the gauge level filter: FSM state encoding,
// display defaults and the bar-height clamp helper.
package gauge_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } gauge_state_e;

  localparam int SCREEN_H_DEFAULT = 272;
  localparam int LEVEL_W          = 9;

  function automatic logic [LEVEL_W-1:0] clamp_level(
    input logic [LEVEL_W-1:0] raw,
    input logic [LEVEL_W-1:0] top
  );
    return (raw > top) ? top : raw;
  endfunction

endpackage

// File: rtl/moving_average.sv
// Circular buffer of the last 2^AVG_LOG2 samples with a running sum; exposes
// the top LEVEL_W bits of the average (sum >> AVG_LOG2).
module moving_average
  import gauge_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                wipe_en,
  input  logic [AVG_LOG2-1:0] wipe_idx,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   din,
  output logic [LEVEL_W-1:0]  avg_msb
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;

  logic [DATA_W-1:0]   buf_q [N];
  logic [DATA_W-1:0]   buf_d [N];
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [SUM_W-1:0]    sum_q, sum_d;

  // The sum holds at most N full-scale samples, so SUM_W bits cannot overflow.
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    if (clr) begin
      wr_ptr_d = '0;
      sum_d    = '0;
    end else if (wr_en) begin
      buf_d[wr_ptr_q] = din;
      sum_d           = sum_q + SUM_W'(din) - SUM_W'(buf_q[wr_ptr_q]);
      wr_ptr_d        = wr_ptr_q + AVG_LOG2'(1);
    end
    if (wipe_en) begin
      buf_d[wipe_idx] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      sum_q    <= '0;
    end else begin
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      sum_q    <= sum_d;
    end
  end

  assign avg_msb = sum_q[SUM_W-1 -: LEVEL_W];

endmodule

// File: rtl/gauge_level_filter.sv
// Sensor-to-bar-height filter: periodic sampling, moving average, clamp to the
// screen and optional peak-hold marker (compiled in with GAUGE_PEAK_HOLD_EN).
module gauge_level_filter
  import gauge_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int AVG_LOG2        = 3,
  parameter int SAMPLE_PERIOD   = 270000,
  parameter int SCREEN_H        = SCREEN_H_DEFAULT,
  parameter int PEAK_HOLD_TICKS = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  sample_in,
  input  logic               flush,
  output logic [8:0]         level,
  output logic               level_valid,
  output logic [8:0]         peak,
  output logic               busy,
  output gauge_state_e       dbg_state
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int CNT_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [AVG_LOG2-1:0] IDX_LAST  = AVG_LOG2'(N - 1);
  localparam logic [LEVEL_W-1:0]  LEVEL_TOP = LEVEL_W'(SCREEN_H - 1);

  if (DATA_W < LEVEL_W || PEAK_HOLD_TICKS < 0) begin : g_bad_params
    $error("gauge_level_filter: DATA_W must be >= 9 and PEAK_HOLD_TICKS >= 0");
  end

  gauge_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AVG_LOG2-1:0] wipe_idx_q, wipe_idx_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                cap_q, cap_d;
  logic                upd_q, upd_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic                level_valid_q, level_valid_d;
  logic                busy_q, busy_d;

  logic                tick;
  logic                ma_clr, ma_wipe_en, ma_wr_en;
  logic [LEVEL_W-1:0]  avg_msb;
  logic [LEVEL_W-1:0]  new_level;

`ifdef GAUGE_PEAK_HOLD_EN
  localparam int HOLD_W = (PEAK_HOLD_TICKS > 0) ? $clog2(PEAK_HOLD_TICKS + 1) : 1;
  logic [LEVEL_W-1:0] peak_q, peak_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
`endif

  moving_average #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (ma_clr),
    .wipe_en  (ma_wipe_en),
    .wipe_idx (wipe_idx_q),
    .wr_en    (ma_wr_en),
    .din      (sample_q),
    .avg_msb  (avg_msb)
  );

  assign tick      = (cnt_q == CNT_LAST);
  assign new_level = clamp_level(avg_msb, LEVEL_TOP);

  // Pipeline: cap_q marks a captured sample, upd_q marks a fresh running sum.
  always_comb begin
    state_d       = state_q;
    cnt_d         = tick ? '0 : cnt_q + CNT_W'(1);
    wipe_idx_d    = wipe_idx_q;
    sample_d      = sample_q;
    cap_d         = 1'b0;
    upd_d         = 1'b0;
    level_d       = level_q;
    level_valid_d = 1'b0;
    busy_d        = busy_q;
    ma_clr        = 1'b0;
    ma_wipe_en    = 1'b0;
    ma_wr_en      = 1'b0;
`ifdef GAUGE_PEAK_HOLD_EN
    peak_d        = peak_q;
    hold_d        = hold_q;
`endif
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d    = FLUSH;
          busy_d     = 1'b1;
          wipe_idx_d = '0;
          ma_clr     = 1'b1;
          level_d    = '0;
`ifdef GAUGE_PEAK_HOLD_EN
          peak_d     = '0;
          hold_d     = '0;
`endif
        end else begin
          if (tick) begin
            sample_d = sample_in;
            cap_d    = 1'b1;
          end
          ma_wr_en = cap_q;
          upd_d    = cap_q;
          if (upd_q) begin
            level_d       = new_level;
            level_valid_d = 1'b1;
`ifdef GAUGE_PEAK_HOLD_EN
            if (new_level >= peak_q) begin
              peak_d = new_level;
              hold_d = HOLD_W'(PEAK_HOLD_TICKS);
            end else if (hold_q != '0) begin
              hold_d = hold_q - HOLD_W'(1);
            end else begin
              peak_d = (peak_q - LEVEL_W'(1) < new_level) ? new_level : peak_q - LEVEL_W'(1);
            end
`endif
          end
        end
      end
      FLUSH: begin
        ma_wipe_en = 1'b1;
        wipe_idx_d = wipe_idx_q + AVG_LOG2'(1);
        if (wipe_idx_q == IDX_LAST) begin
          state_d = RUN;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      wipe_idx_q    <= '0;
      sample_q      <= '0;
      cap_q         <= 1'b0;
      upd_q         <= 1'b0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef GAUGE_PEAK_HOLD_EN
      peak_q        <= '0;
      hold_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wipe_idx_q    <= wipe_idx_d;
      sample_q      <= sample_d;
      cap_q         <= cap_d;
      upd_q         <= upd_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      busy_q        <= busy_d;
`ifdef GAUGE_PEAK_HOLD_EN
      peak_q        <= peak_d;
      hold_q        <= hold_d;
`endif
    end
  end

  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign busy        = busy_q;
  assign dbg_state   = state_q;
`ifdef GAUGE_PEAK_HOLD_EN
  assign peak        = peak_q;
`else
  assign peak        = level_q;
`endif

endmodule

// File: doc/gauge_level_filter.md
GAUGE_LEVEL_FILTER -- requirements
Module: gauge_level_filter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the raw sensor value width.
REQ-002 SHALL have parameter AVG_LOG2, default 3, meaning log2 of the moving-average depth N.
REQ-003 SHALL have parameter SAMPLE_PERIOD, default 270000, meaning clocks between sample captures.
REQ-004 SHALL have parameter SCREEN_H, default 272, meaning the display height in pixels.
REQ-005 SHALL have parameter PEAK_HOLD_TICKS, default 50, meaning sample ticks the peak is held before decay.
REQ-006 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-low.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port sample_in, input, DATA_W, the selected raw sensor value (distance, encoder or combination).
REQ-009 SHALL have port flush, input, 1, a single-cycle pulse requesting a history clear (source changed).
REQ-010 SHALL have port level, output, 9, the filtered bar height, 0..SCREEN_H-1.
REQ-011 SHALL have port level_valid, output, 1, a one-cycle strobe when level updates.
REQ-012 SHALL have port peak, output, 9, the peak-hold marker height.
REQ-013 SHALL have port busy, output, 1, high while a flush is in progress.

Function
REQ-014 The free-running tick counter SHALL count 0..SAMPLE_PERIOD-1 and raise tick for one cycle on wrap.
REQ-015 In state RUN, on tick, sample_in SHALL be captured (cycle T) and the buffer and sum updated at T+1.
REQ-016 The circular buffer SHALL hold N=2^AVG_LOG2 entries; a write pointer SHALL wrap from N-1 to 0.
REQ-017 The running sum SHALL be DATA_W+AVG_LOG2 bits wide, with sum_next = sum + new - buf[wr_ptr], and SHALL never overflow.
REQ-018 avg SHALL equal sum >> AVG_LOG2, truncated.
REQ-019 level SHALL equal min(avg[DATA_W-1:DATA_W-9], SCREEN_H-1), registered at T+2; level_valid SHALL pulse at T+2.
REQ-020 On flush in RUN, the FSM SHALL enter FLUSH, raise busy, and zero one buffer entry per cycle over N cycles.
REQ-021 In FLUSH, sum, wr_ptr and level SHALL be cleared; FLUSH SHALL then return to RUN and drop busy.
REQ-022 Ticks during FLUSH SHALL be discarded, and flush during FLUSH SHALL be ignored.
REQ-023 When flush and tick coincide, flush SHALL win and the sample SHALL be discarded.
REQ-024 Peak, on level_valid: if level >= peak, peak SHALL take level and the hold counter SHALL reload to PEAK_HOLD_TICKS.
REQ-025 Peak, on level_valid: otherwise, if the hold counter is nonzero it SHALL decrement; if zero, peak SHALL decrement by 1, never below level.
REQ-026 Flush SHALL clear peak and the hold counter.

Reset
REQ-027 While rst_n=0 at a clk edge, state SHALL be RUN and all counters, pointers, sum and buffer entries SHALL be 0.
REQ-028 While rst_n=0, level, peak, level_valid and busy SHALL be 0.
REQ-029 Reset asserted mid-FLUSH or mid-update SHALL abort the operation and leave no partial state.

Configuration
REQ-030 With GAUGE_PEAK_HOLD_EN defined, the peak logic of REQ-024..026 SHALL be compiled in.
REQ-031 Without GAUGE_PEAK_HOLD_EN, the peak logic and hold counter SHALL be absent and peak SHALL equal level.

Structure
REQ-032 The FSM state enum (RUN, FLUSH) and the default SCREEN_H constant SHALL live in the shared package gauge_pkg.
REQ-033 The circular buffer with running sum SHALL be the sub-module moving_average.

Verification (AVG_LOG2=3, SAMPLE_PERIOD=4, PEAK_HOLD_TICKS=2)
REQ-034 Scenario: reset, then sample_in=16'h4000 constant -> after the 1st tick level=16; after the 8th tick level=128 and stays 128.
REQ-035 Scenario: sample_in=16'hFFFF for 8 ticks -> level=271 (clamped), and level never exceeds 271.
REQ-036 Scenario: level steady at 128, then sample_in=0 -> peak=128 for 2 ticks, then decrements 1 per tick while level falls.
REQ-037 Scenario: flush coincident with tick -> busy high for 8 cycles, level=0, peak=0, and no level_valid until the next tick after busy falls.
REQ-038 Scenario: rst_n low for 1 cycle in the middle of FLUSH -> all outputs 0 the next cycle, and normal ramp-up from 0 after release.
REQ-039 Scenario: build without GAUGE_PEAK_HOLD_EN -> peak equals level on every cycle across scenarios REQ-034..036.
